mac_vec_pipe: RTL and testbench



---
 rtl/mac_vec_if.sv | 27 ++
 rtl/mac_vec_pipe.sv | 141 ++++++++++++++
 tb/tb_mac_vec_pipe.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mac_vec_if.sv
// Handshake bus for mac_vec_pipe: operand beats in, frame results out.
// Master drives beats and result acceptance; slave is the MAC itself.
interface mac_vec_if #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 4,
    parameter int ACC_WIDTH = 24
);
    logic                        in_valid;
    logic                        in_ready;
    logic                        in_last;
    logic [LANES*WIDTH-1:0]      w;
    logic [LANES*WIDTH-1:0]      x;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [ACC_WIDTH-1:0] out_data;
    logic                        out_ovf;

    modport master (
        output in_valid, in_last, w, x, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_last, w, x, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/mac_vec_pipe.sv
// Three-stage multi-lane signed MAC with per-frame accumulation and result hold.
// Define MAC_SATURATE_EN to clamp the accumulator and report per-frame overflow.
module mac_vec_pipe #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 4,
    parameter int ACC_WIDTH = 24
) (
    input  logic      clk,
    input  logic      rst,
    mac_vec_if.slave  io_bus
);
    localparam int PW = 2 * WIDTH;
    localparam int SW = PW + $clog2(LANES);

    logic                        w_stall;
    logic                        w_accept;
    logic signed [PW-1:0]        w_prod [LANES];
    logic signed [SW-1:0]        w_lane_sum;
    logic signed [ACC_WIDTH-1:0] w_acc_base;
    logic signed [ACC_WIDTH-1:0] w_acc_next;
    logic                        w_s3_fire;

    logic signed [PW-1:0]        r_prod [LANES];
    logic                        r_v1;
    logic                        r_last1;
    logic signed [SW-1:0]        r_sum;
    logic                        r_v2;
    logic                        r_last2;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic                        r_first;
    logic                        r_out_valid;
    logic signed [ACC_WIDTH-1:0] r_out_data;

    assign w_stall         = r_out_valid & ~io_bus.out_ready;
    assign w_accept        = io_bus.in_valid & ~w_stall;
    assign w_s3_fire       = r_v2 & ~w_stall;
    assign io_bus.in_ready = ~w_stall;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_out_data;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_prod[i] = PW'($signed(io_bus.w[i*WIDTH +: WIDTH]))
                      * PW'($signed(io_bus.x[i*WIDTH +: WIDTH]));
        end
    end

    always_comb begin
        w_lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lane_sum = w_lane_sum + SW'(r_prod[i]);
        end
    end

    assign w_acc_base = r_first ? '0 : r_acc;

`ifdef MAC_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] w_acc_wide;
    logic                      w_clamp;
    logic                      w_frame_ovf_next;
    logic                      r_frame_ovf;
    logic                      r_out_ovf;

    // The extra top bit disagreeing with the sign bit means the sum left the ACC_WIDTH range
    always_comb begin
        w_acc_wide = (ACC_WIDTH+1)'(w_acc_base) + (ACC_WIDTH+1)'(r_sum);
        w_clamp    = w_acc_wide[ACC_WIDTH] ^ w_acc_wide[ACC_WIDTH-1];
        if (!w_clamp) begin
            w_acc_next = w_acc_wide[ACC_WIDTH-1:0];
        end else if (w_acc_wide[ACC_WIDTH]) begin
            w_acc_next = ACC_MIN;
        end else begin
            w_acc_next = ACC_MAX;
        end
        w_frame_ovf_next = (r_first ? 1'b0 : r_frame_ovf) | w_clamp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_ovf <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else if (w_s3_fire) begin
            r_frame_ovf <= w_frame_ovf_next;
            if (r_last2) begin
                r_out_ovf <= w_frame_ovf_next;
            end
        end
    end

    assign io_bus.out_ovf = r_out_ovf;
`else
    assign w_acc_next     = w_acc_base + ACC_WIDTH'(r_sum);
    assign io_bus.out_ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                r_prod[i] <= '0;
            end
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
            r_sum   <= '0;
            r_v2    <= 1'b0;
            r_last2 <= 1'b0;
        end else if (!w_stall) begin
            for (int i = 0; i < LANES; i++) begin
                r_prod[i] <= w_prod[i];
            end
            r_v1    <= w_accept;
            r_last1 <= w_accept & io_bus.in_last;
            r_sum   <= w_lane_sum;
            r_v2    <= r_v1;
            r_last2 <= r_last1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_first     <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_s3_fire) begin
                r_acc   <= w_acc_next;
                r_first <= r_last2;
            end
            // A new result on the handshake edge keeps out_valid high
            if (w_s3_fire && r_last2) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_acc_next;
            end else if (io_bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mac_vec_pipe.sv
// Self-checking bench for mac_vec_pipe: vector table, latency, backpressure,
// overflow (both MAC_SATURATE_EN builds) and reset corner cases.
module tb_mac_vec_pipe;
    localparam int WIDTH     = 8;
    localparam int LANES     = 4;
    localparam int ACC_WIDTH = 18;

`ifdef MAC_SATURATE_EN
    localparam int OVF_DATA = 131071;
    localparam int OVF_FLAG = 1;
`else
    localparam int OVF_DATA = -131072;
    localparam int OVF_FLAG = 0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mac_vec_if #(.WIDTH(WIDTH), .LANES(LANES), .ACC_WIDTH(ACC_WIDTH)) bus ();

    mac_vec_pipe #(.WIDTH(WIDTH), .LANES(LANES), .ACC_WIDTH(ACC_WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    typedef struct {
        int   data;
        logic ovf;
    } exp_t;

    typedef struct {
        logic [31:0] w;
        logic [31:0] x;
        logic        last;
        int          exp;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[7];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [31:0] pack4(int a, int b, int c, int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: sample at negedge (acceptance + scoreboard), return 1ns after posedge
    task automatic tick(output logic acc);
        exp_t e;
        @(negedge clk);
        acc = bus.in_valid & bus.in_ready;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got %0d, expected no result", int'(bus.out_data));
            end else begin
                e = sb.pop_front();
                check("result", int'(bus.out_data), e.data);
                check("result_ovf", int'(bus.out_ovf), int'(e.ovf));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        logic a;
        tick(a);
    endtask

    task automatic drive(logic [31:0] w, logic [31:0] x, logic last);
        logic a = 1'b0;
        int   n = 0;
        bus.in_valid = 1'b1;
        bus.w        = w;
        bus.x        = x;
        bus.in_last  = last;
        while (!a && n < 50) begin
            tick(a);
            n++;
        end
        if (!a) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got no acceptance, expected acceptance within 50 cycles");
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        tbl[0] = '{pack4(1, 2, 3, 4),         pack4(5, 6, 7, 8),         1'b1, 70};
        tbl[1] = '{pack4(-3, 0, 0, 0),        pack4(2, 0, 0, 0),         1'b0, 0};
        tbl[2] = '{pack4(5, 0, 0, 0),         pack4(-4, 0, 0, 0),        1'b1, -26};
        tbl[3] = '{pack4(6, 0, 0, 0),         pack4(-8, 0, 0, 0),        1'b1, -48};
        tbl[4] = '{pack4(127, 127, 127, 127), pack4(127, 127, 127, 127), 1'b0, 0};
        tbl[5] = '{pack4(-128, -128, -128, -128), pack4(127, 127, 127, 127), 1'b1, -508};
        tbl[6] = '{pack4(-1, 2, -3, 4),       pack4(7, -7, 7, -7),       1'b1, -70};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.w         = '0;
        bus.x         = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready",  int'(bus.in_ready),  1);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_out_data",  int'(bus.out_data),  0);
        check("reset_out_ovf",   int'(bus.out_ovf),   0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single-beat frame: result valid after the third edge
        sb.push_back('{70, 1'b0});
        drive(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1);
        step();
        check("latency_edge_k1", int'(bus.out_valid), 0);
        step();
        check("latency_edge_k2", int'(bus.out_valid), 1);
        step();

        // Back-to-back frames from the vector table
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].last) sb.push_back('{tbl[i].exp, 1'b0});
            drive(tbl[i].w, tbl[i].x, tbl[i].last);
        end
        repeat (6) step();

        // Backpressure: three frames in flight, downstream holds off for 5 cycles
        bus.out_ready = 1'b0;
        sb.push_back('{70, 1'b0});
        sb.push_back('{-48, 1'b0});
        sb.push_back('{24, 1'b0});
        drive(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1);
        drive(pack4(6, 0, 0, 0), pack4(-8, 0, 0, 0), 1'b1);
        drive(pack4(2, 2, 2, 2), pack4(3, 3, 3, 3), 1'b1);
        repeat (5) begin
            step();
            check("stall_in_ready",  int'(bus.in_ready),  0);
            check("stall_out_valid", int'(bus.out_valid), 1);
            check("stall_out_data",  int'(bus.out_data),  70);
        end
        bus.out_ready = 1'b1;
        repeat (8) step();

        // Overflow frame, then a clean frame must not inherit the flag
        sb.push_back('{OVF_DATA, OVF_FLAG[0]});
        drive(pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -128), 1'b0);
        drive(pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -128), 1'b1);
        sb.push_back('{70, 1'b0});
        drive(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1);
        repeat (6) step();

        // Asynchronous reset between edges with a result pending
        bus.out_ready = 1'b0;
        drive(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1);
        step();
        step();
        check("pending_before_rst", int'(bus.out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", int'(bus.out_valid), 0);
        check("async_rst_out_data",  int'(bus.out_data),  0);
        check("async_rst_out_ovf",   int'(bus.out_ovf),   0);
        check("async_rst_in_ready",  int'(bus.in_ready),  1);
        @(negedge clk);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Mid-frame reset discards the partial frame
        drive(pack4(1, 1, 1, 1), pack4(10, 10, 10, 10), 1'b0);
        step();
        #2;
        rst = 1'b1;
        #1;
        check("midframe_rst_out_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        sb.push_back('{70, 1'b0});
        drive(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1);
        repeat (6) step();

        n = 0;
        while (sb.size() > 0 && n < 20) begin
            step();
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
